// File: rtl/ripple_mon_pkg.sv
// Shared types and helpers for the ripple-counter monitor.
package ripple_mon_pkg;

  localparam int unsigned MaxWidth = 8;

  typedef enum logic [1:0] {
    StAcquire = 2'b00,
    StTrack   = 2'b01,
    StFault   = 2'b10
  } state_e;

  // Forward distance from b to a, modulo 2^w (w <= MaxWidth).
  function automatic logic [MaxWidth-1:0] mod_delta(logic [MaxWidth-1:0] a,
                                                    logic [MaxWidth-1:0] b,
                                                    int unsigned w);
    logic [MaxWidth-1:0] mask;
    mask = MaxWidth'((1 << w) - 1);
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/ripple_count_monitor_sample_qualifier.sv
// Three-stage sampler for the asynchronous counter value; flags a value held for two samples.
module ripple_count_monitor_sample_qualifier
  import ripple_mon_pkg::*;
#(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [Width-1:0] q_i,
  output logic             qual_o,
  output logic [Width-1:0] qv_o
);

  logic [Width-1:0] s1_q, s2_q, s3_q;
  logic [1:0]       cnt_q;
  logic             primed;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      s1_q <= q_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
      if (cnt_q != 2'd3) cnt_q <= cnt_q + 2'd1;
    end
  end

  assign primed = (cnt_q == 2'd3);
  assign qual_o = primed && (s2_q == s3_q);
  assign qv_o   = s2_q;

endmodule

// File: rtl/ripple_count_monitor.sv
// Tracks a sampled ripple counter, extends it across wraps and flags thresholds and bad jumps.
module ripple_count_monitor
  import ripple_mon_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned EXT_W    = 16,
  parameter int unsigned MAX_STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q_in,
  input  logic             clear,
  input  logic [EXT_W-1:0] thresh,
  output logic             count_valid,
  output logic [WIDTH-1:0] stable_q,
  output logic [EXT_W-1:0] ext_count,
  output logic             wrap_pulse,
  output logic             thresh_hit,
  output logic             sat,
  output logic             fault,
  output logic [1:0]       state_o
);

  localparam logic [WIDTH-1:0] MaxStepW = WIDTH'(MAX_STEP);
  localparam logic [EXT_W-1:0] ExtMax   = '1;

  logic             qual;
  logic [WIDTH-1:0] qv, delta;
  logic [EXT_W:0]   sum;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [EXT_W-1:0] ext_q, ext_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             thr_q, thr_d;
  logic             sat_q, sat_d;
  logic             fault_q, fault_d;

  ripple_count_monitor_sample_qualifier #(
    .Width(WIDTH)
  ) u_qual (
    .clk_i  (clk),
    .reset_i(reset),
    .q_i    (q_in),
    .qual_o (qual),
    .qv_o   (qv)
  );

  assign delta = WIDTH'(mod_delta(MaxWidth'(qv), MaxWidth'(last_q), WIDTH));
  assign sum   = {1'b0, ext_q} + {{(EXT_W + 1 - WIDTH){1'b0}}, delta};

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    ext_d   = ext_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    sat_d   = sat_q;
    fault_d = fault_q;
    if (clear) begin
      state_d = StAcquire;
      last_d  = '0;
      ext_d   = '0;
      valid_d = 1'b0;
      sat_d   = 1'b0;
      fault_d = 1'b0;
    end else begin
      unique case (state_q)
        StAcquire: begin
          if (qual) begin
            last_d  = qv;
            ext_d   = '0;
            valid_d = 1'b1;
            state_d = StTrack;
          end
        end
        StTrack: begin
          if (qual && delta != '0) begin
            if (delta <= MaxStepW) begin
              last_d = qv;
              wrap_d = (qv < last_q);
              if (sum >= {1'b0, ExtMax}) begin
                ext_d = ExtMax;
                sat_d = 1'b1;
              end else begin
                ext_d = sum[EXT_W-1:0];
              end
            end else begin
              fault_d = 1'b1;
              state_d = StFault;
            end
          end
        end
        StFault: ;
        default: state_d = StAcquire;
      endcase
    end
    thr_d = valid_d && (ext_d >= thresh);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StAcquire;
      last_q  <= '0;
      ext_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      thr_q   <= 1'b0;
      sat_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      ext_q   <= ext_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      thr_q   <= thr_d;
      sat_q   <= sat_d;
      fault_q <= fault_d;
    end
  end

  assign count_valid = valid_q;
  assign stable_q    = last_q;
  assign ext_count   = ext_q;
  assign wrap_pulse  = wrap_q;
  assign thresh_hit  = thr_q;
  assign sat         = sat_q;
  assign fault       = fault_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor: a 16-bit instance plus a 4-bit one for saturation.
module tb_ripple_count_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  q_in;
  logic        clear;
  logic [15:0] thresh;
  logic        count_valid, wrap_pulse, thresh_hit, sat, fault;
  logic [3:0]  stable_q;
  logic [15:0] ext_count;
  logic [1:0]  state_o;

  logic [3:0]  q2;
  logic        clear2;
  logic [3:0]  thresh2;
  logic        cv2, wrap2, thr2, sat2, fault2;
  logic [3:0]  stable2, ext2;
  logic [1:0]  state2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ripple_count_monitor #(
    .WIDTH(4), .EXT_W(16), .MAX_STEP(1)
  ) dut (
    .clk(clk), .reset(reset), .q_in(q_in), .clear(clear), .thresh(thresh),
    .count_valid(count_valid), .stable_q(stable_q), .ext_count(ext_count),
    .wrap_pulse(wrap_pulse), .thresh_hit(thresh_hit), .sat(sat), .fault(fault),
    .state_o(state_o)
  );

  ripple_count_monitor #(
    .WIDTH(4), .EXT_W(4), .MAX_STEP(1)
  ) dut_sat (
    .clk(clk), .reset(reset), .q_in(q2), .clear(clear2), .thresh(thresh2),
    .count_valid(cv2), .stable_q(stable2), .ext_count(ext2),
    .wrap_pulse(wrap2), .thresh_hit(thr2), .sat(sat2), .fault(fault2),
    .state_o(state2)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold a new value long enough to be qualified and accepted.
  task automatic step(input logic [3:0] v);
    q_in = v;
    tick(4);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; q_in = 4'h5; thresh = 16'hFFFF;
    q2 = 4'h0; clear2 = 1'b0; thresh2 = 4'hF;
    tick(2);
    chk("rst_valid", 32'(count_valid), 32'd0);
    chk("rst_stable", 32'(stable_q), 32'd0);
    chk("rst_ext", 32'(ext_count), 32'd0);
    chk("rst_flags", {28'd0, wrap_pulse, thresh_hit, sat, fault}, 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);

    reset = 1'b0;
    tick(3);
    chk("acq_not_yet", 32'(count_valid), 32'd0);
    tick();
    chk("acq_valid", 32'(count_valid), 32'd1);
    chk("acq_stable", 32'(stable_q), 32'h5);
    chk("acq_state", 32'(state_o), 32'd1);

    // 5 -> 6: visible only after the fourth edge
    q_in = 4'h6;
    tick(3);
    chk("lat_early", 32'(ext_count), 32'd0);
    tick();
    chk("lat_ext", 32'(ext_count), 32'd1);
    chk("lat_stable", 32'(stable_q), 32'h6);
    chk("lat_nowrap", 32'(wrap_pulse), 32'd0);

    // one-cycle glitch to 9, then 7
    q_in = 4'h9;
    tick();
    q_in = 4'h7;
    tick(4);
    chk("glitch_ext", 32'(ext_count), 32'd2);
    chk("glitch_stable", 32'(stable_q), 32'h7);
    chk("glitch_nofault", 32'(fault), 32'd0);

    for (int v = 8; v < 16; v++) step(4'(v));
    chk("pre_wrap_ext", 32'(ext_count), 32'd10);
    chk("pre_wrap_pulse", 32'(wrap_pulse), 32'd0);
    step(4'h0);
    chk("wrap_pulse", 32'(wrap_pulse), 32'd1);
    chk("wrap_stable", 32'(stable_q), 32'h0);
    chk("wrap_ext", 32'(ext_count), 32'd11);
    tick();
    chk("wrap_one_cycle", 32'(wrap_pulse), 32'd0);

    // 0 -> 3 is an illegal jump
    step(4'h3);
    chk("fault_flag", 32'(fault), 32'd1);
    chk("fault_state", 32'(state_o), 32'd2);
    chk("fault_ext", 32'(ext_count), 32'd11);
    chk("fault_stable", 32'(stable_q), 32'h0);
    step(4'h9);
    chk("fault_frozen", 32'(ext_count), 32'd11);
    chk("fault_stays", 32'(state_o), 32'd2);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_ext", 32'(ext_count), 32'd0);
    chk("clr_state", 32'(state_o), 32'd0);
    chk("clr_valid", 32'(count_valid), 32'd0);
    tick();
    chk("reacq_stable", 32'(stable_q), 32'h9);
    chk("reacq_valid", 32'(count_valid), 32'd1);

    thresh = 16'd3;
    tick();
    chk("thr_zero", 32'(thresh_hit), 32'd0);
    step(4'hA);
    step(4'hB);
    chk("thr_two", 32'(thresh_hit), 32'd0);
    step(4'hC);
    chk("thr_three", 32'(thresh_hit), 32'd1);
    chk("thr_ext", 32'(ext_count), 32'd3);

    // reset mid-operation must re-prime
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_valid", 32'(count_valid), 32'd0);
    chk("mrst_ext", 32'(ext_count), 32'd0);
    chk("mrst_thr", 32'(thresh_hit), 32'd0);
    tick(3);
    chk("mrst_not_yet", 32'(count_valid), 32'd0);
    tick();
    chk("mrst_valid2", 32'(count_valid), 32'd1);
    chk("mrst_stable", 32'(stable_q), 32'hC);

    // 4-bit extension: sixteen increments saturate at 15
    chk("sat_start", {28'd0, ext2}, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      q2 = 4'(i);
      tick(4);
      if (i == 14) begin
        chk("sat_14_ext", {28'd0, ext2}, 32'd14);
        chk("sat_14_flag", 32'(sat2), 32'd0);
      end
    end
    chk("sat_ext", {28'd0, ext2}, 32'd15);
    chk("sat_flag", 32'(sat2), 32'd1);
    chk("sat_wrap", 32'(wrap2), 32'd1);
    chk("sat_nofault", 32'(fault2), 32'd0);
    chk("sat_thr", 32'(thr2), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
